day5_input_parser: RTL and testbench

DAY5_INPUT_PARSER -- requirements
Module: day5_input_parser

---
 rtl/day5_input_parser.sv | 157 +++++++++++++++
 tb/tb_day5_input_parser.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/day5_input_parser.sv
// Streaming parser for the day-5 puzzle file: "lo-hi" range lines, a blank line,
// then one ID per line. Emits one registered pulse per parsed range or ID.
module day5_input_parser #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             load_ranges,
  output logic [WIDTH-1:0] start_range,
  output logic [WIDTH-1:0] end_range,
  output logic             id_valid,
  output logic [WIDTH-1:0] id,
  output logic [15:0]      range_count,
  output logic [15:0]      id_count,
  output logic             done,
  output logic             error,
  output logic [2:0]       state_dbg
);

  // Handshake: a byte is consumed on any rising edge where in_valid && in_ready;
  // in_ready depends only on the current state, never on in_valid.

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_END   = 3'd1,
    S_ID    = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_DASH = 8'h2D;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] start_hold, hold_n;
  logic             has_digit, hd_n;
  logic             emit_range, emit_id;
  logic [WIDTH-1:0] id_val;
  logic             accept, is_digit;

  assign in_ready  = (state == S_START) || (state == S_END) || (state == S_ID);
  assign accept    = in_valid && in_ready;
  assign is_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign state_dbg = state;

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    hold_n     = start_hold;
    hd_n       = has_digit;
    emit_range = 1'b0;
    emit_id    = 1'b0;
    id_val     = acc;
    if (accept) begin
      if (is_digit) begin
        acc_n = acc * WIDTH'(10) + WIDTH'(in_data - 8'h30);
        hd_n  = 1'b1;
      end else if (in_data != CH_CR) begin
        case (state)
          S_START: begin
            if (in_data == CH_DASH && has_digit) begin
              hold_n  = acc;
              acc_n   = '0;
              hd_n    = 1'b0;
              state_n = S_END;
            end else if (in_data == CH_LF && !has_digit) begin
              state_n = S_ID;
            end else begin
              state_n = S_ERR;
            end
          end
          S_END: begin
            if (in_data == CH_LF && has_digit) begin
              emit_range = 1'b1;
              acc_n      = '0;
              hd_n       = 1'b0;
              state_n    = S_START;
            end else begin
              state_n = S_ERR;
            end
          end
          S_ID: begin
            if (in_data == CH_LF && has_digit) begin
              emit_id = 1'b1;
              id_val  = acc;
              acc_n   = '0;
              hd_n    = 1'b0;
            end else if (in_data == CH_LF) begin
              state_n = S_DONE;
            end else begin
              state_n = S_ERR;
            end
          end
          default: state_n = S_ERR;
        endcase
      end
      // End of file: flush a pending ID, reject a half-written range line.
      if (in_last) begin
        case (state_n)
          S_ID: begin
            if (hd_n) begin
              emit_id = 1'b1;
              id_val  = acc_n;
              acc_n   = '0;
              hd_n    = 1'b0;
            end
            state_n = S_DONE;
          end
          S_START: state_n = hd_n ? S_ERR : S_DONE;
          S_END:   state_n = S_ERR;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_START;
      acc         <= '0;
      start_hold  <= '0;
      has_digit   <= 1'b0;
      load_ranges <= 1'b0;
      id_valid    <= 1'b0;
      start_range <= '0;
      end_range   <= '0;
      id          <= '0;
      range_count <= '0;
      id_count    <= '0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      start_hold  <= hold_n;
      has_digit   <= hd_n;
      load_ranges <= emit_range;
      id_valid    <= emit_id;
      if (emit_range) begin
        start_range <= start_hold;
        end_range   <= acc;
        range_count <= range_count + 16'd1;
      end
      if (emit_id) begin
        id       <= id_val;
        id_count <= id_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_day5_input_parser.sv
// Directed bench for day5_input_parser: a 64-bit instance checked through a pulse
// scoreboard, plus an 8-bit instance sharing the same inputs for the truncation case.
module tb_day5_input_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;

  logic        in_ready, load_ranges, id_valid, done, error;
  logic [63:0] start_range, end_range, id;
  logic [15:0] range_count, id_count;
  logic [2:0]  state_dbg;

  logic        in_ready8, load_ranges8, id_valid8, done8, error8;
  logic [7:0]  start_range8, end_range8, id8;
  logic [15:0] range_count8, id_count8;
  logic [2:0]  state_dbg8;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_range_q[$];
  logic [63:0]  exp_id_q[$];

  day5_input_parser #(.WIDTH(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .load_ranges(load_ranges),
    .start_range(start_range), .end_range(end_range), .id_valid(id_valid),
    .id(id), .range_count(range_count), .id_count(id_count), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  day5_input_parser #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready8), .load_ranges(load_ranges8),
    .start_range(start_range8), .end_range(end_range8), .id_valid(id_valid8),
    .id(id8), .range_count(range_count8), .id_count(id_count8), .done(done8),
    .error(error8), .state_dbg(state_dbg8)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #3;
    check("rst_state", state_dbg, 3'd0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_flags", {load_ranges, id_valid, done, error}, 4'b0000);
    check("rst_counts", {range_count, id_count}, 32'd0);
    check("rst_outs", {start_range, end_range}, 128'd0);
    check("rst_id", id, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // driver
  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_final, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom_range(0, 255));
          @(posedge clock);
          #1;
        end
      end
      send(s[i], last_on_final && (i == s.len() - 1));
    end
  endtask

  task automatic settle_and_drain(input string tag);
    repeat (2) @(posedge clock);
    #1;
    check({tag, "_ranges_left"}, 128'(exp_range_q.size()), 128'd0);
    check({tag, "_ids_left"}, 128'(exp_id_q.size()), 128'd0);
  endtask

  // scoreboard: every pulse on the 64-bit instance must match the next expected item
  always @(negedge clock) begin
    if (!reset) begin
      if (load_ranges || id_valid)
        check("pulse_exclusive", 128'(load_ranges & id_valid), 128'd0);
      if (load_ranges) begin
        if (exp_range_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL range_unexpected observed %0d-%0d expected none", start_range, end_range);
        end else begin
          check("range_pulse", {start_range, end_range}, exp_range_q.pop_front());
        end
      end
      if (id_valid) begin
        if (exp_id_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL id_unexpected observed %0d expected none", id);
        end else begin
          check("id_pulse", id, exp_id_q.pop_front());
        end
      end
    end
  end

  initial begin
    // reset state
    do_reset();

    // two ranges, two IDs, terminated by a blank line
    exp_range_q.push_back({64'd3, 64'd5});
    exp_range_q.push_back({64'd10, 64'd14});
    exp_id_q.push_back(64'd1);
    exp_id_q.push_back(64'd5);
    send_str("3-5\n10-14\n\n1\n5\n\n", 1'b0, 1'b0);
    settle_and_drain("t1");
    check("t1_counts", {range_count, id_count}, {16'd2, 16'd2});
    check("t1_done", {done, error, in_ready}, 3'b100);
    check("t1_range_hold", {start_range, end_range}, {64'd10, 64'd14});

    // in_last flushes a trailing ID with one-cycle latency
    do_reset();
    exp_range_q.push_back({64'd1, 64'd2});
    exp_id_q.push_back(64'd17);
    send_str("1-2\n\n1", 1'b0, 1'b0);
    send("7", 1'b1);
    check("t2_id_latency", {id_valid, id}, {1'b1, 64'd17});
    check("t2_done", {done, error}, 2'b10);
    settle_and_drain("t2");
    check("t2_id_count", id_count, 16'd1);

    // bad delimiter goes to error; reset recovers
    do_reset();
    send_str("4x", 1'b0, 1'b0);
    check("t3_err", {error, done, in_ready}, 3'b100);
    send_str("5\n", 1'b0, 1'b0);
    check("t3_no_range", range_count, 16'd0);
    check("t3_state", state_dbg, 3'd4);
    do_reset();
    exp_range_q.push_back({64'd2, 64'd9});
    send_str("2-9\n", 1'b0, 1'b0);
    settle_and_drain("t3b");
    check("t3b_count", range_count, 16'd1);

    // 8-bit instance wraps the accumulator: 300 mod 256 = 44
    do_reset();
    exp_range_q.push_back({64'd300, 64'd1});
    send_str("300-1\n", 1'b0, 1'b0);
    check("t4_w8_pulse", {load_ranges8, start_range8, end_range8}, {1'b1, 8'd44, 8'd1});
    check("t4_w8_error", {error8, state_dbg8}, {1'b0, 3'd0});
    @(posedge clock);
    #1;
    check("t4_range_count", range_count, 16'd1);

    // reset mid-line clears everything asynchronously
    send_str("12-3", 1'b0, 1'b0);
    check("t5_pre_state", state_dbg, 3'd1);
    reset = 1'b1;
    #1;
    check("t5_async_clear", {range_count, start_range, end_range}, 144'd0);
    check("t5_async_state", state_dbg, 3'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_range_q.push_back({64'd7, 64'd8});
    send_str("7-8\n", 1'b0, 1'b0);
    settle_and_drain("t5");
    check("t5_count", range_count, 16'd1);

    // CRLF stream with idle gaps matches the LF-only result
    do_reset();
    exp_range_q.push_back({64'd5, 64'd6});
    exp_id_q.push_back(64'd9);
    send_str("5-6\015\n\015\n9\015\n\n", 1'b0, 1'b1);
    settle_and_drain("t6");
    check("t6_counts", {range_count, id_count}, {16'd1, 16'd1});
    check("t6_done", {done, error, in_ready}, 3'b100);

    // '-' with no digits is an error
    do_reset();
    send("-", 1'b0);
    check("t7_dash_err", {error, load_ranges}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
